sha_digest_streamer: RTL and testbench

Captures the final SHA-2 digest (SHA-256, SHA-384 or SHA-512) selected by the result-mode select and streams it out MSB-first as a sequence of OUT_W-bit words over a valid/ready handshake. It sits between the hash core's result registers and the host or DMA read-out path. It replaces wide 512-bit result buses with a narrow, back-pressurable stream whose length matches the selected digest.

---
 rtl/sha_digest_streamer_pkg.sv | 11 +
 rtl/sha_digest_streamer_if.sv | 10 +
 rtl/sha_digest_align.sv | 16 +
 rtl/sha_digest_streamer.sv | 74 +++++++
 tb/tb_sha_digest_streamer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sha_digest_streamer_pkg.sv
// sha_pkg: shared digest modes, FSM states, digest widths and word-count helper
package sha_pkg;
  typedef enum logic [1:0] {MODE_256 = 2'b00, MODE_384 = 2'b01, MODE_512 = 2'b10, MODE_INV = 2'b11} mode_e;
  typedef enum logic {IDLE, SEND} state_e;
  localparam int DIG_256 = 256;
  localparam int DIG_384 = 384;
  localparam int DIG_512 = 512;
  function automatic int word_count(mode_e m, int out_w);
    return (m == MODE_256 ? DIG_256 : m == MODE_384 ? DIG_384 : DIG_512) / out_w;
  endfunction
endpackage

// File: rtl/sha_digest_streamer_if.sv
// sha_digest_streamer_if: valid/ready digest word stream with index and last flag
interface sha_digest_streamer_if #(parameter int OUT_W = 32, parameter int CNT_W = 5);
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_idx;
  modport master(output out_valid, out_data, out_last, out_idx, input out_ready);
  modport slave(input out_valid, out_data, out_last, out_idx, output out_ready);
endinterface

// File: rtl/sha_digest_align.sv
// sha_digest_align: selects the digest by mode and left-aligns it into 512 bits
module sha_digest_align
  import sha_pkg::*;
(
  input  logic [1:0]   sel,
  input  logic [255:0] in1,
  input  logic [383:0] in2,
  input  logic [511:0] in3,
  output logic [511:0] aligned
);
  // zero padding sits in the LSBs so the stream always starts at bit 511
  always_comb
    aligned = sel == MODE_256 ? {in1, 256'b0} :
              sel == MODE_384 ? {in2, 128'b0} :
              sel == MODE_512 ? in3 : '0;
endmodule

// File: rtl/sha_digest_streamer.sv
// sha_digest_streamer: captures a SHA-2 digest and streams it MSB-first; SHA_OUT_BSWAP_EN byte-reverses each word
module sha_digest_streamer
  import sha_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            sel_mux_res_sha,
  input  logic [255:0]          in1,
  input  logic [383:0]          in2,
  input  logic [511:0]          in3,
  input  logic                  load,
  input  logic                  flush,
  output logic                  busy,
  output logic                  err_mode,
  sha_digest_streamer_if.master o
);
  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [511:0]     aligned, dig_q;
  logic [CNT_W-1:0] idx_q;
  logic [OUT_W-1:0] word;
  logic             valid, last, xfer, cap, err_d, err_q;
  sha_digest_align u_align (.sel(sel_mux_res_sha), .in1, .in2, .in3, .aligned);
  assign valid = state_q == SEND;
  assign last  = valid && idx_q == CNT_W'(word_count(mode_q, OUT_W) - 1);
  assign word  = dig_q[511 -: OUT_W];
`ifdef SHA_OUT_BSWAP_EN
  logic [OUT_W-1:0] word_sw;
  for (genvar b = 0; b < OUT_W / 8; b++) begin : g_sw
    assign word_sw[8*b +: 8] = word[OUT_W-1-8*b -: 8];
  end
  assign o.out_data = word_sw;
`else
  assign o.out_data = word;
`endif
  assign o.out_valid = valid;
  assign o.out_last  = last;
  assign o.out_idx   = idx_q;
  assign busy        = valid;
  assign err_mode    = err_q;
  // next state: flush dominates, then capture from IDLE, then end of stream
  always_comb begin
    xfer    = valid && o.out_ready;
    cap     = state_q == IDLE && load && !flush && sel_mux_res_sha != MODE_INV;
    err_d   = state_q == IDLE && load && !flush && sel_mux_res_sha == MODE_INV;
    state_d = flush ? IDLE : cap ? SEND : (xfer && last) ? IDLE : state_q;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // capture buffer, latched mode, word index and error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dig_q  <= '0;
      mode_q <= MODE_256;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (flush) idx_q <= '0;
      else if (cap) begin
        dig_q  <= aligned;
        mode_q <= mode_e'(sel_mux_res_sha);
        idx_q  <= '0;
      end else if (xfer) begin
        dig_q <= dig_q << OUT_W;
        idx_q <= last ? '0 : idx_q + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_sha_digest_streamer.sv
// tb_sha_digest_streamer: directed checks of capture, streaming, back-pressure, flush and reset
module tb_sha_digest_streamer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic [255:0] in1 = '0;
  logic [383:0] in2 = '0;
  logic [511:0] in3 = '0;
  logic         load = 1'b0, load64 = 1'b0, flush = 1'b0;
  logic         busy, err, busy64, err64;
  logic [511:0] ref_buf;
  int           checks = 0, errors = 0;
  sha_digest_streamer_if #(.OUT_W(32), .CNT_W(5)) b32 ();
  sha_digest_streamer_if #(.OUT_W(64), .CNT_W(5)) b64 ();
  sha_digest_streamer #(.OUT_W(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .sel_mux_res_sha(sel), .in1(in1), .in2(in2), .in3(in3),
    .load(load), .flush(flush), .busy(busy), .err_mode(err), .o(b32));
  sha_digest_streamer #(.OUT_W(64), .CNT_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .sel_mux_res_sha(sel), .in1(in1), .in2(in2), .in3(in3),
    .load(load64), .flush(flush), .busy(busy64), .err_mode(err64), .o(b64));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] exp_w(input logic [511:0] b, input int k, input int w);
    logic [511:0] t;
    logic [127:0] r, s;
    t = b << (w * k);
    r = t[511:384] >> (128 - w);
    s = r;
`ifdef SHA_OUT_BSWAP_EN
    s = '0;
    for (int i = 0; i < w / 8; i++) s[8*i +: 8] = r[w-1-8*i -: 8];
`endif
    return s;
  endfunction
  initial begin
    b32.out_ready = 1'b0;
    b64.out_ready = 1'b0;
    step();
    chk("rst_valid", b32.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", b32.out_last, 0);
    chk("rst_idx", b32.out_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_data", b32.out_data, 0);
    rst_n = 1'b1;
    step();
    // SHA-256, ready held high
    in1 = {4{64'h0123456789ABCDEF}};
    ref_buf = {in1, 256'b0};
    sel = 2'b00;
    b32.out_ready = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
`ifdef SHA_OUT_BSWAP_EN
    chk("s256_w0_const", b32.out_data, 32'h67452301);
`else
    chk("s256_w0_const", b32.out_data, 32'h01234567);
`endif
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s256_valid%0d", k), b32.out_valid, 1);
      chk($sformatf("s256_idx%0d", k), b32.out_idx, 5'(k));
      chk($sformatf("s256_data%0d", k), b32.out_data, exp_w(ref_buf, k, 32));
      chk($sformatf("s256_last%0d", k), b32.out_last, k == 7);
      step();
    end
    chk("s256_busy_end", busy, 0);
    chk("s256_valid_end", b32.out_valid, 0);
    // SHA-384 with alternating stalls and ignored loads
    for (int k = 0; k < 12; k++) in2[383-32*k -: 32] = 32'hA0B0C000 + 32'(k);
    ref_buf = {in2, 128'b0};
    sel = 2'b01;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b32.out_ready = 1'b0;
      if (k == 5) begin
        load = 1'b1;
        sel = 2'b10;
        in2 = '1;
      end
      step();
      load = 1'b0;
      chk($sformatf("s384_stall_valid%0d", k), b32.out_valid, 1);
      chk($sformatf("s384_stall_idx%0d", k), b32.out_idx, 5'(k));
      chk($sformatf("s384_stall_data%0d", k), b32.out_data, exp_w(ref_buf, k, 32));
      chk($sformatf("s384_last%0d", k), b32.out_last, k == 11);
      b32.out_ready = 1'b1;
      if (k == 11) begin
        load = 1'b1;
        sel = 2'b00;
`ifdef SHA_OUT_BSWAP_EN
        chk("s384_w11", b32.out_data, 32'h0BC0B0A0);
`else
        chk("s384_w11", b32.out_data, 32'hA0B0C00B);
`endif
      end
      step();
      load = 1'b0;
    end
    chk("s384_valid_end", b32.out_valid, 0);
    chk("s384_busy_end", busy, 0);
    // SHA-512 on the 64-bit instance
    for (int k = 0; k < 8; k++) in3[511-64*k -: 64] = 64'h1122334455667700 + 64'(k);
    ref_buf = in3;
    sel = 2'b10;
    b64.out_ready = 1'b1;
    load64 = 1'b1;
    step();
    load64 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s512_idx%0d", k), b64.out_idx, 5'(k));
      chk($sformatf("s512_data%0d", k), b64.out_data, exp_w(ref_buf, k, 64));
      chk($sformatf("s512_last%0d", k), b64.out_last, k == 7);
      step();
    end
    chk("s512_valid_end", b64.out_valid, 0);
    chk("s256_untouched", b32.out_valid, 0);
    // invalid mode
    sel = 2'b11;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("inv_err_hi", err, 1);
    chk("inv_valid", b32.out_valid, 0);
    chk("inv_data", b32.out_data, 0);
    step();
    chk("inv_err_lo", err, 0);
    chk("inv_valid2", b32.out_valid, 0);
    // flush after three words, then restart
    sel = 2'b10;
    b32.out_ready = 1'b1;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fl_data%0d", k), b32.out_data, exp_w(ref_buf, k, 32));
      step();
    end
    chk("fl_idx3", b32.out_idx, 3);
    flush = 1'b1;
    load = 1'b1;
    step();
    flush = 1'b0;
    load = 1'b0;
    chk("fl_valid", b32.out_valid, 0);
    chk("fl_idx", b32.out_idx, 0);
    chk("fl_busy", busy, 0);
    b32.out_ready = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("rs_valid", b32.out_valid, 1);
    chk("rs_idx", b32.out_idx, 0);
    chk("rs_data", b32.out_data, exp_w(ref_buf, 0, 32));
    b32.out_ready = 1'b1;
    step();
    step();
    chk("rs_idx2", b32.out_idx, 2);
    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", b32.out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_idx", b32.out_idx, 0);
    chk("ar_last", b32.out_last, 0);
    chk("ar_data", b32.out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_no_resume", b32.out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
